// File: rtl/mmio_wr_dispatch_if.sv
// Bundle between the CPU store path, the write dispatcher and the demux targets.
// The slave side is the dispatcher; the master side drives requests and acks.
interface mmio_wr_dispatch_if #(
    parameter int SEL_BITS  = 2,
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32
);
    localparam int N = 1 << SEL_BITS;

    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_wdata;
    logic [SEL_BITS-1:0]  dmx_sel;
    logic [DATA_BITS-1:0] dmx_in;
    logic [N-1:0]         tgt_we;
    logic [N-1:0]         tgt_ack;
    logic                 done_valid;
    logic                 done_err;
    logic                 busy;

    modport slave (
        input  req_valid, req_addr, req_wdata, tgt_ack,
        output req_ready, dmx_sel, dmx_in, tgt_we, done_valid, done_err, busy
    );

    modport master (
        output req_valid, req_addr, req_wdata, tgt_ack,
        input  req_ready, dmx_sel, dmx_in, tgt_we, done_valid, done_err, busy
    );
endinterface

// File: rtl/mmio_wr_dispatch.sv
// Store-request sequencer for a 2**SEL_BITS-way write demux: one strobe per request,
// then a bounded wait for the selected target's acknowledge.
module mmio_wr_dispatch #(
    parameter int SEL_BITS  = 2,
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int SEL_LSB   = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst,
    mmio_wr_dispatch_if.slave  bus
);
    localparam int N  = 1 << SEL_BITS;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [N-1:0]  WE_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]           state_r, state_nxt_s;
    logic [CW-1:0]        cnt_r, cnt_nxt_s;
    logic [SEL_BITS-1:0]  sel_r, req_sel_s;
    logic [DATA_BITS-1:0] data_r;
    logic [N-1:0]         we_r, we_nxt_s;
    logic                 done_valid_r, done_err_r;
    logic                 err_nxt_s, accept_s, ack_sel_s;

    assign req_sel_s = bus.req_addr[SEL_LSB +: SEL_BITS];
    // Only the latched target's ack matters; foreign acks never advance the FSM.
    assign ack_sel_s = bus.tgt_ack[sel_r];

    // Next-state, wait-counter and strobe decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        err_nxt_s   = 1'b0;
        accept_s    = 1'b0;
        we_nxt_s    = {N{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s    = 1'b1;
                    we_nxt_s    = WE_ONE << req_sel_s;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_nxt_s = {CW{1'b0}};
                if (ack_sel_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_sel_s) begin
                    state_nxt_s = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, latched demux inputs and registered strobe/completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            sel_r        <= {SEL_BITS{1'b0}};
            data_r       <= {DATA_BITS{1'b0}};
            we_r         <= {N{1'b0}};
            done_valid_r <= 1'b0;
            done_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            we_r         <= we_nxt_s;
            done_valid_r <= (state_nxt_s == ST_RESP);
            done_err_r   <= (state_nxt_s == ST_RESP) && err_nxt_s;
            if (accept_s) begin
                sel_r  <= req_sel_s;
                data_r <= bus.req_wdata;
            end else begin
                sel_r  <= sel_r;
                data_r <= data_r;
            end
        end
    end

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.dmx_sel    = sel_r;
    assign bus.dmx_in     = data_r;
    assign bus.tgt_we     = we_r;
    assign bus.done_valid = done_valid_r;
    assign bus.done_err   = done_err_r;
endmodule

// File: tb/tb_mmio_wr_dispatch.sv
// Directed bench for mmio_wr_dispatch: inline timing checks plus a completion scoreboard.
module tb_mmio_wr_dispatch;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    mmio_wr_dispatch_if #(.SEL_BITS(2), .DATA_BITS(32), .ADDR_BITS(32)) bus ();

    mmio_wr_dispatch #(
        .SEL_BITS(2), .DATA_BITS(32), .ADDR_BITS(32), .SEL_LSB(4), .TIMEOUT(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        chk("we_onehot0", 64'($onehot0(bus.tgt_we)), 64'd1);
        if (bus.done_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_err", 64'(bus.done_err), 64'(e.err));
                chk("sb_sel", 64'(bus.dmx_sel), 64'(e.sel));
                chk("sb_data", 64'(bus.dmx_in), 64'(e.data));
            end
        end
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0020;
        bus.req_wdata = 32'hCAFE_F00D;
        bus.tgt_ack   = 4'b0000;

        // Reset held for two edges with a request pending
        repeat (2) begin
            @(negedge clk);
            chk("rst_we", 64'(bus.tgt_we), 64'd0);
            chk("rst_done", 64'(bus.done_valid), 64'd0);
            chk("rst_sel", 64'(bus.dmx_sel), 64'd0);
            chk("rst_din", 64'(bus.dmx_in), 64'd0);
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        // Zero-wait write to target 2
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0020;
        bus.req_wdata = 32'hDEAD_BEEF;
        bus.tgt_ack   = 4'b0100;
        sb.push_back('{sel: 2'd2, data: 32'hDEAD_BEEF, err: 1'b0});
        @(negedge clk);
        chk("zw_we", 64'(bus.tgt_we), 64'h4);
        chk("zw_sel", 64'(bus.dmx_sel), 64'd2);
        chk("zw_din", 64'(bus.dmx_in), 64'hDEAD_BEEF);
        chk("zw_ready_lo", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("zw_done", 64'(bus.done_valid), 64'd1);
        chk("zw_err", 64'(bus.done_err), 64'd0);
        chk("zw_we_off", 64'(bus.tgt_we), 64'd0);
        @(negedge clk);
        chk("zw_ready", 64'(bus.req_ready), 64'd1);
        chk("zw_done_off", 64'(bus.done_valid), 64'd0);
        chk("zw_din_hold", 64'(bus.dmx_in), 64'hDEAD_BEEF);
        bus.tgt_ack = 4'b0000;

        // Delayed ack from target 1 after three WAIT cycles
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0010;
        bus.req_wdata = 32'h1234_5678;
        sb.push_back('{sel: 2'd1, data: 32'h1234_5678, err: 1'b0});
        @(negedge clk);
        chk("da_we", 64'(bus.tgt_we), 64'h2);
        chk("da_busy_issue", 64'(bus.busy), 64'd1);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("da_wait_we", 64'(bus.tgt_we), 64'd0);
            chk("da_wait_busy", 64'(bus.busy), 64'd1);
            chk("da_wait_done", 64'(bus.done_valid), 64'd0);
        end
        bus.tgt_ack = 4'b0010;
        @(negedge clk);
        chk("da_done", 64'(bus.done_valid), 64'd1);
        chk("da_err", 64'(bus.done_err), 64'd0);
        chk("da_busy_resp", 64'(bus.busy), 64'd1);
        bus.tgt_ack = 4'b0000;
        @(negedge clk);
        chk("da_idle", 64'(bus.req_ready), 64'd1);

        // Timeout on target 3 with only a foreign ack present
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0030;
        bus.req_wdata = 32'hA5A5_A5A5;
        bus.tgt_ack   = 4'b0001;
        sb.push_back('{sel: 2'd3, data: 32'hA5A5_A5A5, err: 1'b1});
        @(negedge clk);
        chk("to_we", 64'(bus.tgt_we), 64'h8);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("to_wait_done", 64'(bus.done_valid), 64'd0);
            chk("to_wait_busy", 64'(bus.busy), 64'd1);
        end
        @(negedge clk);
        chk("to_done", 64'(bus.done_valid), 64'd1);
        chk("to_err", 64'(bus.done_err), 64'd1);
        bus.tgt_ack = 4'b0000;
        @(negedge clk);
        chk("to_idle", 64'(bus.req_ready), 64'd1);

        // Reset on the fifth WAIT cycle of a target-3 request
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0030;
        bus.req_wdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("rw_we", 64'(bus.tgt_we), 64'h8);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rw_wait_busy", 64'(bus.busy), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rw_busy", 64'(bus.busy), 64'd0);
        chk("rw_sel", 64'(bus.dmx_sel), 64'd0);
        chk("rw_din", 64'(bus.dmx_in), 64'd0);
        chk("rw_done", 64'(bus.done_valid), 64'd0);
        rst = 1'b0;
        bus.tgt_ack = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rw_after_we", 64'(bus.tgt_we), 64'd0);
            chk("rw_after_done", 64'(bus.done_valid), 64'd0);
            chk("rw_after_ready", 64'(bus.req_ready), 64'd1);
        end

        // Back-to-back requests with req_valid held high
        bus.tgt_ack   = 4'b1111;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0000;
        bus.req_wdata = 32'h1111_1111;
        sb.push_back('{sel: 2'd0, data: 32'h1111_1111, err: 1'b0});
        @(negedge clk);
        chk("bb_we0", 64'(bus.tgt_we), 64'h1);
        chk("bb_dv1", 64'(bus.done_valid), 64'd0);
        bus.req_addr  = 32'h0000_0010;
        bus.req_wdata = 32'h2222_2222;
        sb.push_back('{sel: 2'd1, data: 32'h2222_2222, err: 1'b0});
        @(negedge clk);
        chk("bb_dv2", 64'(bus.done_valid), 64'd1);
        @(negedge clk);
        chk("bb_dv3", 64'(bus.done_valid), 64'd0);
        chk("bb_ready3", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        chk("bb_we1", 64'(bus.tgt_we), 64'h2);
        chk("bb_dv4", 64'(bus.done_valid), 64'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("bb_dv5", 64'(bus.done_valid), 64'd1);
        @(negedge clk);
        chk("bb_dv6", 64'(bus.done_valid), 64'd0);
        chk("bb_idle", 64'(bus.req_ready), 64'd1);

        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mmio_wr_dispatch.md
Name: mmio_wr_dispatch

Overview:
- Sequences the parameterised write demultiplexer that fans one store data word out to 2**SEL_BITS memory-mapped targets.
- Accepts one store request at a time over a valid/ready handshake and derives the demux select from address bits.
- Issues a one-cycle write strobe to the selected target, then waits for that target's acknowledge, bounded by a timeout.
- Reports completion or error to the CPU-side stall/exception logic.

Parameters:
SEL_BITS, 2, demux select width; number of targets N = 2**SEL_BITS
DATA_BITS, 32, store data width
ADDR_BITS, 32, request address width
SEL_LSB, 4, lowest address bit of the select field: sel = req_addr[SEL_LSB +: SEL_BITS]
TIMEOUT, 15, maximum number of WAIT cycles before error; must be >= 1

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  controller can accept a request
req_addr  input  ADDR_BITS  store address
req_wdata  input  DATA_BITS  store data
dmx_sel  output  SEL_BITS  select to the demux (latched)
dmx_in  output  DATA_BITS  data to the demux input (latched)
tgt_we  output  N  one-hot write strobe; bit i addresses target i
tgt_ack  input  N  per-target acknowledge
done_valid  output  1  one-cycle completion pulse
done_err  output  1  qualifies done_valid; 1 means the request timed out
busy  output  1  high in every state except IDLE

Behaviour:
- State encoding: IDLE, ISSUE, WAIT, RESP.
- Wait counter: width $clog2(TIMEOUT+1).
- Reset (rst=1 at an edge):
  - state=IDLE, counter=0.
  - dmx_sel=0, dmx_in=0, tgt_we=0, done_valid=0, done_err=0.
  - req_ready=1, busy=0 from the first cycle after reset.
- Reset mid-operation: any in-flight request is discarded. No done_valid pulse and no further tgt_we are issued for it.
- req_ready: equals (state==IDLE) and is combinational from state only. It does not depend on req_valid.
- IDLE:
  - If req_valid=1: latch dmx_sel from the address select field and dmx_in from req_wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - tgt_we[dmx_sel]=1; all other bits are 0. counter cleared to 0.
  - If tgt_ack[dmx_sel]=1 in this cycle (zero-wait target), go to RESP with err=0. Otherwise go to WAIT.
- WAIT:
  - tgt_we=0. Only tgt_ack[dmx_sel] is observed; acks from other targets are ignored.
  - If the selected ack is high, go to RESP with err=0.
  - Else if counter==TIMEOUT-1, go to RESP with err=1.
  - Else counter+1 and stay in WAIT.
  - Ack and timeout in the same cycle: the ack wins and err=0.
  - WAIT therefore lasts at most TIMEOUT cycles.
- RESP (exactly one cycle):
  - done_valid=1; done_err holds the registered err flag.
  - Next state is IDLE.
  - done_valid and done_err are 0 in every other state; done_err is only meaningful while done_valid=1.
- dmx_sel and dmx_in hold their latched values from one acceptance until the next acceptance. They change only on acceptance or reset.
- Latency with acceptance at edge E0:
  - ISSUE occupies the cycle after E0.
  - A zero-wait ack gives done_valid in the next cycle.
  - req_ready returns the cycle after that.
  - Minimum issue interval is 3 cycles.
- With req_valid held high continuously, a new request is accepted on every IDLE cycle. Back-to-back transactions therefore start 3 cycles apart.
- tgt_we is one-hot or zero at all times and is never asserted outside ISSUE.

Test Plan:
- Reset values: assert rst for 2 cycles with req_valid=1 -> while rst is high, tgt_we=0, done_valid=0, dmx_sel=0, dmx_in=0; on the first cycle after rst drops, req_ready=1 and busy=0.
- Zero-wait write: req_addr=0x20, wdata=0xDEADBEEF, tgt_ack[2] tied high -> dmx_sel=2, dmx_in=0xDEADBEEF, tgt_we=4'b0100 for one cycle, done_valid=1 with done_err=0 the next cycle, req_ready=1 the cycle after.
- Delayed ack: addr=0x10, tgt_ack[1] raised after 3 WAIT cycles -> tgt_we=4'b0010 for one cycle only, done_valid with err=0 on the cycle after the ack, busy high throughout.
- Timeout with a foreign ack: addr=0x30, only tgt_ack[0] high continuously -> ack ignored, exactly 15 WAIT cycles, then done_valid=1 with done_err=1.
- Reset mid-WAIT: start a request to target 3, assert rst on the 5th WAIT cycle -> IDLE, no done_valid, dmx_sel=0, no further tgt_we.
- Back-to-back requests: req_valid held high, addresses 0x00 then 0x10, all acks high -> two done pulses 3 cycles apart, with tgt_we=4'b0001 then 4'b0010.
